// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants, the RGB444 pixel type and the colour-bar helper.
package vga_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned VGA_H_VISIBLE = 640;
    localparam int unsigned VGA_H_FRONT   = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BACK    = 48;
    localparam int unsigned VGA_V_VISIBLE = 480;
    localparam int unsigned VGA_V_FRONT   = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BACK    = 33;

    localparam int unsigned VGA_H_TOT = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int unsigned VGA_V_TOT = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int unsigned BAR_W = 80;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic rgb444_t bar_colour(input logic [2:0] idx);
        logic [2:0] on;
        case (idx)
            3'd0:    on = 3'b111;
            3'd1:    on = 3'b110;
            3'd2:    on = 3'b011;
            3'd3:    on = 3'b010;
            3'd4:    on = 3'b101;
            3'd5:    on = 3'b100;
            3'd6:    on = 3'b001;
            default: on = 3'b000;
        endcase
        return '{r: {4{on[2]}}, g: {4{on[1]}}, b: {4{on[0]}}};
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping raster counter for one axis, with terminal-count, visible and sync-window flags.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned TOTAL      = VGA_H_TOT,
    parameter int unsigned VISIBLE    = VGA_H_VISIBLE,
    parameter int unsigned SYNC_START = VGA_H_VISIBLE + VGA_H_FRONT,
    parameter int unsigned SYNC_END   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             wrap_c,
    output logic             visible_c,
    output logic             sync_c
);

    assign wrap_c    = (count == CNT_W'(TOTAL - 1));
    assign visible_c = (count < CNT_W'(VISIBLE));
    assign sync_c    = (count >= CNT_W'(SYNC_START)) && (count < CNT_W'(SYNC_END));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= wrap_c ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing plus the registered colour/sync stage toward the DAC.
// Optional colour-bar source enabled by defining VGA_TEST_PATTERN_EN.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE       = VGA_H_VISIBLE,
    parameter int unsigned H_FRONT         = VGA_H_FRONT,
    parameter int unsigned H_SYNC          = VGA_H_SYNC,
    parameter int unsigned H_BACK          = VGA_H_BACK,
    parameter int unsigned V_VISIBLE       = VGA_V_VISIBLE,
    parameter int unsigned V_FRONT         = VGA_V_FRONT,
    parameter int unsigned V_SYNC          = VGA_V_SYNC,
    parameter int unsigned V_BACK          = VGA_V_BACK,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic [3:0]  rgb_in_r,
    input  logic [3:0]  rgb_in_g,
    input  logic [3:0]  rgb_in_b,
    input  logic        test_sel,
    output logic [31:0] row,
    output logic [31:0] col,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        active,
    output logic        frame_start
);

    localparam int unsigned H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    logic             h_wrap_c;
    logic             h_vis_c;
    logic             h_sync_c;
    logic             v_vis_c;
    logic             v_sync_c;
    logic             v_en_c;
    logic             v_wrap_unused;
    logic             vis_c;
    rgb444_t          src_c;
    rgb444_t          pix_q;

    assign v_en_c = pix_en && h_wrap_c;

    vga_axis_counter #(
        .TOTAL      (H_TOT),
        .VISIBLE    (H_VISIBLE),
        .SYNC_START (H_VISIBLE + H_FRONT),
        .SYNC_END   (H_VISIBLE + H_FRONT + H_SYNC)
    ) u_h_axis (
        .clk       (clk),
        .rst       (rst),
        .en        (pix_en),
        .count     (h_count),
        .wrap_c    (h_wrap_c),
        .visible_c (h_vis_c),
        .sync_c    (h_sync_c)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOT),
        .VISIBLE    (V_VISIBLE),
        .SYNC_START (V_VISIBLE + V_FRONT),
        .SYNC_END   (V_VISIBLE + V_FRONT + V_SYNC)
    ) u_v_axis (
        .clk       (clk),
        .rst       (rst),
        .en        (v_en_c),
        .count     (v_count),
        .wrap_c    (v_wrap_unused),
        .visible_c (v_vis_c),
        .sync_c    (v_sync_c)
    );

    assign vis_c = h_vis_c && v_vis_c;
    assign row   = 32'(v_count);
    assign col   = 32'(h_count);

    // Pixel source for the current position: renderer colour, or bars when selected.
    always_comb begin
        src_c = '{r: rgb_in_r, g: rgb_in_g, b: rgb_in_b};
`ifdef VGA_TEST_PATTERN_EN
        if (test_sel) begin
            src_c = bar_colour(3'(h_count / CNT_W'(BAR_W)));
        end
`endif
    end

`ifndef VGA_TEST_PATTERN_EN
    logic test_sel_unused;
    assign test_sel_unused = test_sel;
`endif

    // Output stage captures the position the counters held on the tick, so it lags row/col by one tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync       <= SYNC_ACTIVE_LOW;
            vsync       <= SYNC_ACTIVE_LOW;
            pix_q       <= '0;
            active      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en && (h_count == '0) && (v_count == '0);
            if (pix_en) begin
                active <= vis_c;
                pix_q  <= vis_c ? src_c : '0;
                hsync  <= h_sync_c ^ SYNC_ACTIVE_LOW;
                vsync  <= v_sync_c ^ SYNC_ACTIVE_LOW;
            end
        end
    end

    assign vga_r = pix_q.r;
    assign vga_g = pix_q.g;
    assign vga_b = pix_q.b;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates VGA raster timing for the text/graphics renderers and registers their colour output toward the DAC pins.
- Drives row/col to the combinational render stages and samples the resulting 4:4:4 RGB.
- Blanks the colour outside the visible area and emits hsync/vsync aligned to the registered pixels.
- Sits between the pixel renderers and the DE-10 VGA connector.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE_LOW, 1, 1 = sync pulses drive 0 when asserted

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous reset, active-high
pix_en  in  1  pixel tick, one-cycle strobe (25 MHz rate at 50 MHz clk)
rgb_in_r  in  4  red from render stage for current row/col
rgb_in_g  in  4  green from render stage
rgb_in_b  in  4  blue from render stage
test_sel  in  1  select test pattern (used only with macro)
row  out  32  current line counter, zero-extended, to renderers
col  out  32  current pixel counter, zero-extended, to renderers
hsync  out  1  registered horizontal sync
vsync  out  1  registered vertical sync
vga_r  out  4  registered red to DAC
vga_g  out  4  registered green to DAC
vga_b  out  4  registered blue to DAC
active  out  1  registered visible-area flag, aligned with vga_*
frame_start  out  1  one-clk pulse at the start of each frame

Behaviour:
- Reset (async, rst=1):
  - col=0, row=0.
  - hsync and vsync at their deasserted level (1 when SYNC_ACTIVE_LOW).
  - vga_r/g/b=0, active=0, frame_start=0.
  - Reset mid-frame restarts at (0,0) on the first pix_en after release.
- State only changes on clk edges where pix_en=1. With pix_en=0, all registers hold.
- Horizontal period H_TOT = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800). Vertical period V_TOT = 525.
- On each pix_en tick:
  - col increments. col = H_TOT-1 wraps to 0, and row increments on that same tick.
  - row = V_TOT-1 together with col wrap returns both to 0.
- Internal counters are 10 bits; row/col outputs are combinational from the counters, zero-extended to 32 bits.
- Output register stage, loaded on a pix_en tick while the counters hold (r,c):
  - vis = (c < H_VISIBLE) && (r < V_VISIBLE).
  - active <= vis.
  - vga_* <= vis ? rgb_in : 0.
  - hsync <= asserted iff H_VISIBLE+H_FRONT <= c < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - vsync <= asserted iff V_VISIBLE+V_FRONT <= r < V_VISIBLE+V_FRONT+V_SYNC (490..491).
- Latency: registered outputs lag row/col by exactly one pix_en tick. Sync and colour are always mutually aligned.
- frame_start: asserted for one clk on the cycle after the tick that loads the output register with (0,0).
- Renderers must be combinational on row/col. rgb_in is sampled in the same cycle as the pix_en tick.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined: when test_sel=1, rgb_in is replaced by 8 vertical colour bars, each 80 px wide (bar index = c/80).
  - Each colour component is 4'hF or 4'h0 per bar.
  - Order: white, yellow, cyan, green, magenta, red, blue, black.
  - Blanking still applies.
- Undefined: test_sel is ignored and rgb_in always passes. Port list is identical in both builds.

Decomposition:
- Package vga_pkg holds:
  - 640x480@60 timing localparams and the derived H_TOT/V_TOT.
  - typedef rgb444_t (packed struct of r,g,b 4 bits each).
- Sub-module vga_axis_counter: wrapping counter with enable, wrap-out, and sync-window compare.
  - Instantiated twice: horizontal (enable=pix_en) and vertical (enable=pix_en && h_wrap).

Test Plan:
- Reset, then 800 pix_en ticks → col 0..799 then 0; row steps 0→1 exactly on the wrap tick.
- Full frame (420000 ticks) → hsync low for exactly 96 ticks per line starting at col 656; vsync low for 2 lines (rows 490–491); frame_start pulses once.
- rgb_in=12'hA5C constant → vga_* = A/5/C, active=1, registered for (0,0)..(479,639); 0 with active=0 at col 640 and row 480.
- pix_en held 0 for 37 clks mid-line at col 300 → row/col/outputs frozen; resumes at col 301.
- Assert rst at row 200 col 400 → outputs immediately reset (hsync=vsync=1, vga_*=0); first tick after release loads (0,0).
- With VGA_TEST_PATTERN_EN and test_sel=1 → col 0 white F/F/F, col 80 yellow F/F/0, col 560 black; test_sel=0 → rgb_in passes.
